// File: rtl/display_scan_7seg.sv
// Time-multiplexed multi-digit 7-segment driver with shadowed BCD/dp inputs and a dead cycle per slot.
// Optional leading-zero blanking is compiled in when DISPLAY_SCAN_LZB_EN is defined.
module display_scan_7seg #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic [IdxW-1:0]       scan_idx
);

  logic [CNT_W-1:0]    r_cnt;
  logic [IdxW-1:0]     r_idx;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_dpm;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_wrap;
  logic [CNT_W-1:0]    w_cnt_d;
  logic [IdxW-1:0]     w_idx_d;
  logic [3:0]          w_digit;
  logic                w_dp_bit;
  logic                w_blank_sel;
  logic [DIGITS-1:0]   w_blank;
  logic [6:0]          w_seg_d;
  logic                w_dp_d;
  logic [DIGITS-1:0]   w_an_d;

  assign w_wrap  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_cnt_d = w_wrap ? '0 : r_cnt + CNT_W'(1);

  always_comb begin
    w_idx_d = r_idx;
    if (w_wrap) begin
      w_idx_d = (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  // Walk from the most significant digit; a nonzero digit or a lit dp ends the blank run.
  always_comb begin
    logic w_lead;
    w_lead  = 1'b1;
    w_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_lead = w_lead & (r_bcd[4*i +: 4] == 4'd0) & ~r_dpm[i];
      w_blank[i] = w_lead & (i > 0);
    end
  end
`else
  assign w_blank = '0;
`endif

  // Outputs track the incoming scan position, so seg/dp are valid during the dead cycle.
  always_comb begin
    w_digit     = 4'hF;
    w_dp_bit    = 1'b0;
    w_blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_d == IdxW'(i)) begin
        w_digit     = r_bcd[4*i +: 4];
        w_dp_bit    = r_dpm[i];
        w_blank_sel = w_blank[i];
      end
    end
  end

  always_comb begin
    w_seg_d = 7'b1111111;
    case (w_digit)
      4'd0:    w_seg_d = 7'b0000001;
      4'd1:    w_seg_d = 7'b1001111;
      4'd2:    w_seg_d = 7'b0010010;
      4'd3:    w_seg_d = 7'b0000110;
      4'd4:    w_seg_d = 7'b1001100;
      4'd5:    w_seg_d = 7'b0100100;
      4'd6:    w_seg_d = 7'b0100000;
      4'd7:    w_seg_d = 7'b0001111;
      4'd8:    w_seg_d = 7'b0000000;
      4'd9:    w_seg_d = 7'b0000100;
      default: w_seg_d = 7'b1111111;
    endcase
    if (w_blank_sel) begin
      w_seg_d = 7'b1111111;
    end
    w_dp_d = ~w_dp_bit | w_blank_sel;
  end

  always_comb begin
    w_an_d = {DIGITS{1'b1}};
    if (enable && (w_cnt_d != '0)) begin
      w_an_d = ~(DIGITS'(1) << w_idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_bcd <= {DIGITS{4'hF}};
      r_dpm <= '0;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
      r_an  <= {DIGITS{1'b1}};
    end else begin
      r_cnt <= w_cnt_d;
      r_idx <= w_idx_d;
      if (load) begin
        r_bcd <= digits_bcd;
        r_dpm <= dp_in;
      end
      r_seg <= w_seg_d;
      r_dp  <= w_dp_d;
      r_an  <= w_an_d;
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;
  assign scan_idx = r_idx;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Scoreboard bench for display_scan_7seg (DIGITS=4, REFRESH_DIV=4); expectations follow DISPLAY_SCAN_LZB_EN.
module tb_display_scan_7seg;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] prev_an;

  display_scan_7seg #(
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .CNT_W       (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .digits_bcd (digits_bcd),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .scan_idx   (scan_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic ok, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  // Monitor: each slot start (an leaves all-ones) consumes one expected entry.
  always @(negedge clk) begin
    exp_t e, a;
    if (!reset && prev_an == 4'hF && an != 4'hF && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{an: an, seg: seg, dp: dp, idx: scan_idx};
      check("slot", a === e, 32'(a), 32'(e));
    end
    prev_an <= an;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] bcd, input logic [3:0] dpv);
    digits_bcd = bcd;
    dp_in      = dpv;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  // segs = {seg3, seg2, seg1, seg0}; dps = expected active-low dp per digit {d3..d0}.
  task automatic run_scan(input logic [27:0] segs, input logic [3:0] dps);
    int   t;
    logic [3:0] one;
    t = 0;
    while (!(scan_idx == 2'd3 && an != 4'hF) && t < 40) begin step(); t++; end
    check("wait_digit3", t < 40, 32'(t), 32'd40);
    step();
    for (int i = 0; i < 4; i++) begin
      one = 4'b0001 << i;
      exp_q.push_back('{an: ~one, seg: segs[7*i +: 7], dp: dps[i], idx: 2'(i)});
    end
    t = 0;
    while (exp_q.size() > 0 && t < 40) begin step(); t++; end
    check("drain", t < 40, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_an, one;
    int idx0, t;
    reset = 1'b1; enable = 1'b1; load = 1'b0; digits_bcd = '0; dp_in = '0;
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_an, one;
    int idx0, t;
    #1;
    // Test 1: reset held 3 cycles, load attempted during reset must be ignored.
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin digits_bcd = 16'h1234; dp_in = 4'b1111; load = 1'b1; end
      step();
      check("rst_an", an === 4'hF, 32'(an), 32'hF);
      check("rst_seg_dp_idx", {seg, dp, scan_idx} === {7'h7F, 1'b1, 2'd0},
            32'({seg, dp, scan_idx}), 32'({7'h7F, 1'b1, 2'd0}));
    end
    load = 1'b0; reset = 1'b0;
    for (int s = 0; s < 16; s++) begin
      one    = 4'b0001 << (s / 4);
      exp_an = (s % 4 == 0) ? 4'hF : ~one;
      check("post_rst_an", an === exp_an, 32'(an), 32'(exp_an));
      check("post_rst_seg", {seg, dp} === {7'h7F, 1'b1}, 32'({seg, dp}), 32'({7'h7F, 1'b1}));
      step();
    end

    // Test 2
    do_load(16'h1234, 4'b0010);
    run_scan({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1101);

    // Test 3: slot is one dead cycle plus three active cycles; index wraps 3->0.
    for (int sl = 0; sl < 4; sl++) begin
      t = 0;
      while (an != 4'hF && t < 8) begin step(); t++; end
      check("find_dead", t < 8, 32'(t), 32'd8);
      idx0 = int'(scan_idx);
      one  = 4'b0001 << idx0;
      for (int k = 0; k < 3; k++) begin
        step();
        check("slot_active", an === ~one, 32'(an), 32'(~one));
      end
      step();
      check("slot_dead", {an, scan_idx} === {4'hF, 2'((idx0 + 1) % 4)},
            32'({an, scan_idx}), 32'({4'hF, 2'((idx0 + 1) % 4)}));
    end

    // Test 4: ABF9, then enable low for 10 cycles.
    do_load(16'hABF9, 4'b0000);
    run_scan({7'h7F, 7'h7F, 7'h7F, 7'b0000100}, 4'b1111);
    idx0   = int'(scan_idx);
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("disabled_an", an === 4'hF, 32'(an), 32'hF);
      if (k == 8)
        check("disabled_idx", scan_idx === 2'((idx0 + 2) % 4), 32'(scan_idx),
              32'((idx0 + 2) % 4));
    end
    enable = 1'b1;

    // Test 5: reset in the middle of digit 2's slot.
    t = 0;
    while (!(scan_idx == 2'd2 && an != 4'hF) && t < 40) begin step(); t++; end
    check("wait_digit2", t < 40, 32'(t), 32'd40);
    reset = 1'b1;
    step();
    check("midrst_vals", {an, seg, dp, scan_idx} === {4'hF, 7'h7F, 1'b1, 2'd0},
          32'({an, seg, dp, scan_idx}), 32'({4'hF, 7'h7F, 1'b1, 2'd0}));
    reset = 1'b0;
    step();
    check("resume_d0", {an, seg, dp, scan_idx} === {4'b1110, 7'h7F, 1'b1, 2'd0},
          32'({an, seg, dp, scan_idx}), 32'({4'b1110, 7'h7F, 1'b1, 2'd0}));

    // Test 6: leading-zero handling.
    do_load(16'h0050, 4'b0000);
`ifdef DISPLAY_SCAN_LZB_EN
    run_scan({7'h7F, 7'h7F, 7'b0100100, 7'b0000001}, 4'b1111);
`else
    run_scan({7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b1111);
`endif
    do_load(16'h0005, 4'b0010);
`ifdef DISPLAY_SCAN_LZB_EN
    run_scan({7'h7F, 7'h7F, 7'b0000001, 7'b0100100}, 4'b1101);
`else
    run_scan({7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100}, 4'b1101);
`endif

    check("queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
